// File: rtl/bus_downsizer.sv
// bus_downsizer
//
// Width adapter between a wide single-word master port (A) and a narrow
// slave port (B). Each A access is split into Ratio = BusWidthA/BusWidthB
// narrow beats, mapped little-endian. Read beats are issued back-to-back,
// and returns are collected independently, so several reads can be
// outstanding on B at the same time.
//
// Optional feature macro: BUS_DOWNSIZER_SPARSE_WRITE_EN
//   When defined, write beats whose byte-enable slice is all zero are
//   skipped. A write with no enabled bytes completes without any B traffic.
//   When undefined, every write issues all Ratio beats.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   addr_a            A byte address (low bits below word size ignored)
//   w_data_a, w_sel_a A write data / byte enables
//   re_a, we_a        A read / write request, held until completion
//   r_data_a          assembled read word (held until next read completes)
//   r_data_valid_a    one-cycle pulse, r_data_a valid
//   ready_a           one-cycle pulse, write complete
//   addr_b            narrow beat address
//   w_data_b, w_sel_b narrow beat write data / byte enables
//   re_b, we_b        narrow beat request
//   ready_b           beat accepted when high together with re_b or we_b
//   r_data_b          narrow read data
//   r_data_valid_b    read beat returned (in order, latency >= 1)

module bus_downsizer #(
    parameter int AddrBusWidth = 32,
    parameter int BusWidthA    = 32,
    parameter int BusWidthB    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [AddrBusWidth-1:0]   addr_a,
    input  logic [BusWidthA-1:0]      w_data_a,
    input  logic [BusWidthA/8-1:0]    w_sel_a,
    input  logic                      re_a,
    input  logic                      we_a,
    output logic [BusWidthA-1:0]      r_data_a,
    output logic                      r_data_valid_a,
    output logic                      ready_a,
    output logic [AddrBusWidth-1:0]   addr_b,
    output logic [BusWidthB-1:0]      w_data_b,
    output logic [BusWidthB/8-1:0]    w_sel_b,
    output logic                      re_b,
    output logic                      we_b,
    input  logic                      ready_b,
    input  logic [BusWidthB-1:0]      r_data_b,
    input  logic                      r_data_valid_b
);

    localparam int Ratio     = BusWidthA / BusWidthB;
    localparam int LoW       = $clog2(Ratio);
    localparam int IdxW      = LoW + 1;
    localparam int SelA      = BusWidthA / 8;
    localparam int SelB      = BusWidthB / 8;
    localparam int AlignBits = $clog2(SelA);
    localparam int BeatShift = $clog2(SelB);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD      = 2'd1,
        RD_WAIT = 2'd2,
        WR      = 2'd3
    } state_t;

    state_t                 state_reg, state_next;
    logic [IdxW-1:0]        issue_reg, issue_next;
    logic [IdxW-1:0]        ret_reg, ret_next;
    logic                   ready_reg, ready_next;
    logic [BusWidthA-1:0]   held_reg;

    logic [BusWidthA-1:0]   asm_word;
    logic [BusWidthB-1:0]   wdata_slice [Ratio];
    logic [SelB-1:0]        wsel_slice  [Ratio];
    logic                   collect;
    logic                   read_done;
    logic [LoW-1:0]         beat_lo;
    logic [AddrBusWidth-1:0] aligned_addr;
    logic [AddrBusWidth-1:0] beat_offset;
    logic [IdxW-1:0]        first_beat;
    logic [IdxW-1:0]        after_beat;

    // Low address bits select bytes inside the wide word and are not used.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_a[AlignBits-1:0];

    // Return collection is only live while a read is in progress; anything
    // arriving in IDLE or WR (e.g. stragglers after a reset) is dropped.
    assign collect   = ((state_reg == RD) || (state_reg == RD_WAIT)) &&
                       r_data_valid_b && (ret_reg < IdxW'(Ratio));
    assign read_done = (state_reg == RD_WAIT) && (ret_reg == IdxW'(Ratio));

    assign beat_lo      = issue_reg[LoW-1:0];
    assign aligned_addr = {addr_a[AddrBusWidth-1:AlignBits], {AlignBits{1'b0}}};
    assign beat_offset  = AddrBusWidth'(beat_lo) << BeatShift;

    // Per-lane slicing of the wide write word and per-lane read assembly.
    generate
        for (genvar gi = 0; gi < Ratio; gi++) begin : g_lane
            logic [BusWidthB-1:0] lane_reg;

            assign wdata_slice[gi] = w_data_a[gi*BusWidthB +: BusWidthB];
            assign wsel_slice[gi]  = w_sel_a[gi*SelB +: SelB];
            assign asm_word[gi*BusWidthB +: BusWidthB] = lane_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_reg <= '0;
                end else if (collect && (ret_reg == IdxW'(gi))) begin
                    lane_reg <= r_data_b;
                end
            end
        end
    endgenerate

`ifdef BUS_DOWNSIZER_SPARSE_WRITE_EN
    logic [Ratio-1:0] slice_en;

    generate
        for (genvar gi = 0; gi < Ratio; gi++) begin : g_en
            assign slice_en[gi] = |wsel_slice[gi];
        end
    endgenerate

    // First beat at or after 'start' with any byte enabled; Ratio if none.
    function automatic logic [IdxW-1:0] next_beat(input logic [IdxW-1:0] start);
        next_beat = IdxW'(Ratio);
        for (int k = Ratio - 1; k >= 0; k--) begin
            if ((IdxW'(k) >= start) && slice_en[k]) begin
                next_beat = IdxW'(k);
            end
        end
    endfunction
`else
    // Every beat is issued, so the next beat is simply the following one.
    function automatic logic [IdxW-1:0] next_beat(input logic [IdxW-1:0] start);
        next_beat = start;
    endfunction
`endif

    assign first_beat = next_beat('0);
    assign after_beat = next_beat(issue_reg + IdxW'(1));

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            issue_reg <= '0;
            ret_reg   <= '0;
            ready_reg <= 1'b0;
            held_reg  <= '0;
        end else begin
            state_reg <= state_next;
            issue_reg <= issue_next;
            ret_reg   <= ret_next;
            ready_reg <= ready_next;
            if (read_done) begin
                held_reg <= asm_word;
            end
        end
    end

    // Next-state and B-side outputs.
    always_comb begin
        state_next     = state_reg;
        issue_next     = issue_reg;
        ret_next       = ret_reg;
        ready_next     = 1'b0;
        re_b           = 1'b0;
        we_b           = 1'b0;
        addr_b         = '0;
        w_data_b       = '0;
        w_sel_b        = '0;
        r_data_valid_a = 1'b0;

        if (collect) begin
            ret_next = ret_reg + IdxW'(1);
        end

        case (state_reg)
            IDLE: begin
                issue_next = '0;
                ret_next   = '0;
                // The write-complete pulse cycle is not a sampling point: the
                // master is still holding the finished request during it.
                if (!ready_reg) begin
                    if (we_a) begin
                        if (first_beat == IdxW'(Ratio)) begin
                            ready_next = 1'b1;
                        end else begin
                            state_next = WR;
                            issue_next = first_beat;
                        end
                    end else if (re_a) begin
                        state_next = RD;
                    end
                end
            end

            RD: begin
                re_b   = 1'b1;
                addr_b = aligned_addr + beat_offset;
                if (ready_b) begin
                    issue_next = issue_reg + IdxW'(1);
                    if (issue_reg == IdxW'(Ratio - 1)) begin
                        state_next = RD_WAIT;
                    end
                end
            end

            RD_WAIT: begin
                if (read_done) begin
                    r_data_valid_a = 1'b1;
                    state_next     = IDLE;
                    issue_next     = '0;
                    ret_next       = '0;
                end
            end

            WR: begin
                we_b     = 1'b1;
                addr_b   = aligned_addr + beat_offset;
                w_data_b = wdata_slice[beat_lo];
                w_sel_b  = wsel_slice[beat_lo];
                if (ready_b) begin
                    if (after_beat == IdxW'(Ratio)) begin
                        ready_next = 1'b1;
                        state_next = IDLE;
                        issue_next = '0;
                    end else begin
                        issue_next = after_beat;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ready_a  = ready_reg;
    // The fresh word is visible during the completion pulse; afterwards the
    // held copy keeps it stable while the next read's lanes fill in.
    assign r_data_a = r_data_valid_a ? asm_word : held_reg;

endmodule

// File: tb/tb_bus_downsizer.sv
// Testbench for bus_downsizer in the 32/8 configuration. A byte-array RAM
// slave with programmable read latency and stall injection sits on the B
// port; a separate byte-array reference model predicts read words, write
// beats and completion latencies.
// Honours BUS_DOWNSIZER_SPARSE_WRITE_EN when predicting write beats.

module tb_bus_downsizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr_a;
    logic [31:0] w_data_a;
    logic [3:0]  w_sel_a;
    logic        re_a, we_a;
    logic [31:0] r_data_a;
    logic        r_data_valid_a, ready_a;
    logic [31:0] addr_b;
    logic [7:0]  w_data_b;
    logic [0:0]  w_sel_b;
    logic        re_b, we_b;
    logic        ready_b;
    logic [7:0]  r_data_b;
    logic        r_data_valid_b;

    always #5 clk = ~clk;

    bus_downsizer #(
        .AddrBusWidth(32),
        .BusWidthA   (32),
        .BusWidthB   (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .addr_a        (addr_a),
        .w_data_a      (w_data_a),
        .w_sel_a       (w_sel_a),
        .re_a          (re_a),
        .we_a          (we_a),
        .r_data_a      (r_data_a),
        .r_data_valid_a(r_data_valid_a),
        .ready_a       (ready_a),
        .addr_b        (addr_b),
        .w_data_b      (w_data_b),
        .w_sel_b       (w_sel_b),
        .re_b          (re_b),
        .we_b          (we_b),
        .ready_b       (ready_b),
        .r_data_b      (r_data_b),
        .r_data_valid_b(r_data_valid_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] ref_mem [256];
    logic [7:0] slv_mem [256];

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic        we;
        logic [7:0]  data;
        logic        sel;
    } beat_t;

    typedef struct {
        logic [7:0] data;
        int         due;
    } ret_t;

    beat_t       beat_log [$];
    ret_t        ret_q [$];
    logic [31:0] stall_snap [$];
    int lat = 1;
    int stall_beat = -1;
    int stall_left = 0;
    int beat_cnt = 0;
    int acc_total = 0;
    int ret_total = 0;
    int peak = 0;

    // RAM slave: all its outputs change mid-cycle, away from the DUT edge.
    always @(negedge clk) begin
        if (acc_total - ret_total > peak) peak = acc_total - ret_total;
        r_data_valid_b = 1'b0;
        if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            r_data_valid_b = 1'b1;
            r_data_b = ret_q[0].data;
            void'(ret_q.pop_front());
            ret_total++;
        end
        ready_b = 1'b1;
        if ((re_b || we_b) && beat_cnt == stall_beat && stall_left > 0) begin
            ready_b = 1'b0;
            stall_left--;
            stall_snap.push_back(addr_b);
        end
        if ((re_b || we_b) && ready_b) begin
            beat_log.push_back('{cyc: cyc, addr: addr_b, we: we_b, data: w_data_b, sel: w_sel_b[0]});
            beat_cnt++;
            if (re_b) begin
                ret_q.push_back('{data: slv_mem[addr_b[7:0]], due: cyc + lat});
                acc_total++;
            end else if (w_sel_b[0]) begin
                slv_mem[addr_b[7:0]] = w_data_b;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input int l, input int sb,
                           input int sl, input string tag);
        logic [31:0] al, expw, got;
        int start, stamp, pulses;
        al = a & ~32'h3;
        expw = {ref_mem[al[7:0] + 8'd3], ref_mem[al[7:0] + 8'd2],
                ref_mem[al[7:0] + 8'd1], ref_mem[al[7:0]]};
        lat = l; stall_beat = sb; stall_left = sl; beat_cnt = 0; peak = 0;
        beat_log.delete(); stall_snap.delete();
        @(posedge clk); #1;
        addr_a = a; re_a = 1'b1; start = cyc;
        stamp = -1; pulses = 0; got = '0;
        for (int i = 0; i < 40 && stamp < 0; i++) begin
            @(negedge clk);
            if (r_data_valid_a) begin
                pulses++; stamp = cyc - start; got = r_data_a; re_a = 1'b0;
            end
        end
        re_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (r_data_valid_a) pulses++;
        end
        check({tag, "_lat"}, stamp, 5 + l + sl);
        check({tag, "_data"}, got, expw);
        check({tag, "_pulses"}, pulses, 1);
        check({tag, "_nbeats"}, beat_log.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < beat_log.size())
                check({tag, "_beat", $sformatf("%0d", k)},
                      {beat_log[k].addr, 7'd0, beat_log[k].we}, {al + 32'(k), 8'd0});
        end
        if (beat_log.size() == 4) begin
            check({tag, "_first_cyc"}, beat_log[0].cyc - start, 1);
            check({tag, "_last_cyc"}, beat_log[3].cyc - start, 4 + sl);
        end
        if (sl > 0) begin
            check({tag, "_nstall"}, stall_snap.size(), sl);
            foreach (stall_snap[k]) check({tag, "_stall_addr"}, stall_snap[k], al + 32'(sb));
        end else begin
            check({tag, "_peak"}, peak, (l < 4) ? l : 4);
        end
        $display("READ  %s addr=%08h data=%08h exp=%08h lat=%0d", tag, a, got, expw, stamp);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] sel, input logic both, input string tag);
        logic [31:0] al;
        beat_t exp_q [$];
        int start, stamp, rpulses, npulses;
        al = a & ~32'h3;
        for (int k = 0; k < 4; k++) begin
`ifdef BUS_DOWNSIZER_SPARSE_WRITE_EN
            if (sel[k])
`endif
            exp_q.push_back('{cyc: 0, addr: al + 32'(k), we: 1'b1, data: d[8*k +: 8], sel: sel[k]});
            if (sel[k]) ref_mem[al[7:0] + 8'(k)] = d[8*k +: 8];
        end
        lat = 1; stall_beat = -1; stall_left = 0; beat_cnt = 0;
        beat_log.delete();
        @(posedge clk); #1;
        addr_a = a; w_data_a = d; w_sel_a = sel; we_a = 1'b1; re_a = both;
        start = cyc; stamp = -1; rpulses = 0; npulses = 0;
        for (int i = 0; i < 40 && stamp < 0; i++) begin
            @(negedge clk);
            if (r_data_valid_a) rpulses++;
            if (ready_a) begin
                npulses++; stamp = cyc - start; we_a = 1'b0; re_a = 1'b0;
            end
        end
        we_a = 1'b0; re_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (r_data_valid_a) rpulses++;
            if (ready_a) npulses++;
        end
        check({tag, "_lat"}, stamp, exp_q.size() + 1);
        check({tag, "_ready_pulses"}, npulses, 1);
        check({tag, "_no_rd_valid"}, rpulses, 0);
        check({tag, "_nbeats"}, beat_log.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < beat_log.size())
                check({tag, "_beat", $sformatf("%0d", k)},
                      {beat_log[k].addr, beat_log[k].data, 7'd0, beat_log[k].sel, 7'd0, beat_log[k].we},
                      {exp_q[k].addr, exp_q[k].data, 7'd0, exp_q[k].sel, 8'd1});
        end
        $display("WRITE %s addr=%08h data=%08h sel=%b beats=%0d lat=%0d", tag, a, d, sel, beat_log.size(), stamp);
    endtask

    initial begin
        int pulses, nlog;
        logic [31:0] ra, rd;
        logic [3:0] rs;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'($urandom);
            slv_mem[i] = ref_mem[i];
        end
        rst_n = 1'b0; re_a = 1'b0; we_a = 1'b0;
        addr_a = 32'h44; w_data_a = 32'hA5A5_5A5A; w_sel_a = 4'hF;
        ready_b = 1'b1; r_data_b = '0; r_data_valid_b = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_b_side", {re_b, we_b, addr_b, w_data_b, w_sel_b}, '0);
        check("reset_a_side", {ready_a, r_data_valid_a, r_data_a}, '0);
        rst_n = 1'b1;
        $display("RESET released at cycle %0d", cyc);

        do_read(32'h08, 1, -1, 0, "rd08");
        do_write(32'h08, 32'hDEAD_BEEF, 4'b1001, 1'b0, "wr08");
        do_read(32'h09, 1, -1, 0, "rd08_back");
        do_read(32'h0C, 1, 2, 3, "rd_stall");
        do_read(32'h14, 3, -1, 0, "rd_lat3");

        // Reset in the middle of a read with slow returns still in flight.
        lat = 3; stall_left = 0; beat_cnt = 0; beat_log.delete();
        @(posedge clk); #1;
        addr_a = 32'h20; re_a = 1'b1;
        for (int i = 0; i < 10 && beat_log.size() == 0; i++) @(negedge clk);
        #2 rst_n = 1'b0; re_a = 1'b0;
        #1;
        check("midrst_b_side", {re_b, we_b, addr_b, w_data_b, w_sel_b}, '0);
        check("midrst_a_side", {ready_a, r_data_valid_a, r_data_a}, '0);
        nlog = beat_log.size();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (r_data_valid_a) pulses++;
        end
        check("midrst_no_valid", pulses, 0);
        check("midrst_rdata_zero", r_data_a, 32'h0);
        check("midrst_no_beats", beat_log.size(), nlog);
        $display("RESET mid-read beats_before=%0d stray_returns_drained=%0d", nlog, (ret_q.size() == 0));
        do_read(32'h10, 1, -1, 0, "rd_post_rst");

        do_write(32'h30, 32'h1234_5678, 4'b0110, 1'b1, "wr_both");
        do_read(32'h30, 2, -1, 0, "rd_both_back");
        do_write(32'h40, 32'hCAFE_F00D, 4'b0000, 1'b0, "wr_nosel");
        do_write(32'h44, 32'h0BAD_F00D, 4'b1111, 1'b0, "wr_full");
        do_read(32'h40, 1, -1, 0, "rd_40");
        do_read(32'h44, 1, -1, 0, "rd_44");

        for (int t = 0; t < 10; t++) begin
            ra = 32'($urandom_range(0, 62)) * 4 + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                rd = $urandom;
                rs = 4'($urandom_range(0, 15));
                do_write(ra, rd, rs, 1'b0, $sformatf("rnd_wr%0d", t));
            end else begin
                do_read(ra, $urandom_range(1, 4), -1, 0, $sformatf("rnd_rd%0d", t));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
